// File: rtl/mem_requester.sv
// Single-outstanding command initiator for the 64K x 32 two-phase-read memory.
// Optional build macro REQ_STATS_EN adds saturating read/write counters (rd_count, wr_count).
module mem_requester #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [4:0]        cmd_bit,
   input  logic [1:0]        cmd_byte,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_rd_opcode,
   output logic [4:0]        mem_bit_addr,
   output logic [1:0]        mem_byte_addr,
   output logic [DATA_W-1:0] mem_wr_bus,
   input  logic [DATA_W-1:0] mem_rd_bus,
   output logic [2:0]        dbg_state
`ifdef REQ_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_RD_HOLD = 3'd2,
      S_RD_CAP  = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          op_q, op_d;
   logic [4:0]          bit_q, bit_d;
   logic [1:0]          byte_q, byte_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                cmd_accept;
   logic                rsp_accept;

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high. cmd_ready depends only on state (never on cmd_valid); rsp_valid
   // stays high with rsp_data frozen until the edge on which rsp_ready is seen.
   assign cmd_accept = cmd_valid && cmd_ready;
   assign rsp_accept = rsp_valid_q && rsp_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (cmd_accept) state_d = S_ISSUE;
         S_ISSUE:   state_d = wr_q ? S_IDLE : S_RD_HOLD;
         S_RD_HOLD: state_d = S_RD_CAP;
         S_RD_CAP:  state_d = S_RESP;
         S_RESP:    if (rsp_accept) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs; strobes are additionally gated by reset so they drop at once.
   always_comb begin
      cmd_ready = reset && (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      mem_wr_en = reset && (state_q == S_ISSUE) && wr_q;
      mem_rd_en = reset && (state_q == S_ISSUE) && !wr_q;
      dbg_state = state_q;
   end

   // The captured command doubles as the registered memory pin drive, so the
   // selects stay put through RD_HOLD and after the command completes.
   always_comb begin
      wr_d    = wr_q;
      addr_d  = addr_q;
      op_d    = op_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      wdata_d = wdata_q;
      if (cmd_accept) begin
         wr_d    = cmd_write;
         addr_d  = cmd_addr;
         op_d    = cmd_op;
         bit_d   = cmd_bit;
         byte_d  = cmd_byte;
         wdata_d = cmd_wdata;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (state_q == S_RD_CAP) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = mem_rd_bus;
      end else if (state_q == S_RESP && rsp_accept) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q        <= 1'b0;
         addr_q      <= '0;
         op_q        <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         op_q        <= op_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign mem_addr      = addr_q;
   assign mem_rd_opcode = op_q;
   assign mem_bit_addr  = bit_q;
   assign mem_byte_addr = byte_q;
   assign mem_wr_bus    = wdata_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;

`ifdef REQ_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   // Both counters stick at all-ones instead of wrapping.
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (state_q == S_RD_CAP && rd_count_q != 16'hFFFF) begin
         rd_count_d = rd_count_q + 16'd1;
      end
      if (state_q == S_ISSUE && wr_q && wr_count_q != 16'hFFFF) begin
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: vector table of reads/writes plus hand-written
// sequences for response back-pressure and mid-operation reset.
module tb_mem_requester;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam logic [31:0] BUS_IDLE = 32'hA5A5_A5A5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_write = 1'b0;
   logic [1:0]        cmd_op = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [4:0]        cmd_bit = '0;
   logic [1:0]        cmd_byte = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_rd_opcode;
   logic [4:0]        mem_bit_addr;
   logic [1:0]        mem_byte_addr;
   logic [DATA_W-1:0] mem_wr_bus;
   logic [DATA_W-1:0] mem_rd_bus = BUS_IDLE;
   logic [2:0]        dbg_state;
`ifdef REQ_STATS_EN
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;
`endif

   int checks = 0;
   int errors = 0;
   int exp_rd = 0;
   int exp_wr = 0;

   mem_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_bit(cmd_bit),
      .cmd_byte(cmd_byte), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_rd_opcode(mem_rd_opcode),
      .mem_bit_addr(mem_bit_addr), .mem_byte_addr(mem_byte_addr),
      .mem_wr_bus(mem_wr_bus), .mem_rd_bus(mem_rd_bus), .dbg_state(dbg_state)
`ifdef REQ_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_wr;
      logic [1:0]  op;
      logic [15:0] addr;
      logic [4:0]  bsel;
      logic [1:0]  ysel;
      logic [31:0] wdata;
      logic [31:0] bus;
      int          hold;
      logic [31:0] exp_rsp;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input vec_t v);
      cmd_valid = 1'b1;
      cmd_write = v.is_wr;
      cmd_op    = v.op;
      cmd_addr  = v.addr;
      cmd_bit   = v.bsel;
      cmd_byte  = v.ysel;
      cmd_wdata = v.wdata;
   endtask

   task automatic do_write(input vec_t v);
      check("wr_ready_before", cmd_ready, 1);
      drive_cmd(v);
      tick();
      cmd_valid = 1'b0;
      check("wr_strobe", mem_wr_en, 1);
      check("wr_no_rd", mem_rd_en, 0);
      check("wr_addr", mem_addr, v.addr);
      check("wr_bus", mem_wr_bus, v.wdata);
      check("wr_ready_low", cmd_ready, 0);
      check("wr_busy", busy, 1);
      tick();
      check("wr_strobe_end", mem_wr_en, 0);
      check("wr_ready_back", cmd_ready, 1);
      check("wr_busy_end", busy, 0);
      exp_wr++;
   endtask

   task automatic do_read(input vec_t v);
      check("rd_ready_before", cmd_ready, 1);
      drive_cmd(v);
      tick();
      cmd_valid = 1'b0;
      check("rd_strobe", mem_rd_en, 1);
      check("rd_no_wr", mem_wr_en, 0);
      check("rd_addr", mem_addr, v.addr);
      check("rd_ready_low", cmd_ready, 0);
      tick();
      check("hold_strobes", {mem_rd_en, mem_wr_en}, 0);
      check("hold_opcode", mem_rd_opcode, v.op);
      check("hold_bit", mem_bit_addr, v.bsel);
      check("hold_byte", mem_byte_addr, v.ysel);
      check("hold_no_rsp", rsp_valid, 0);
      tick();
      // Only the RD_CAP cycle carries the real read data.
      mem_rd_bus = v.bus;
      check("cap_no_rsp", rsp_valid, 0);
      check("cap_strobes", {mem_rd_en, mem_wr_en}, 0);
      tick();
      mem_rd_bus = ~v.bus;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, v.exp_rsp);
      check("rsp_ready_low", cmd_ready, 0);
      exp_rd++;
      for (int i = 0; i < v.hold; i++) begin
         // A write presented while the response is pending must be ignored.
         cmd_valid = 1'b1;
         cmd_write = 1'b1;
         tick();
         check("bp_valid", rsp_valid, 1);
         check("bp_data", rsp_data, v.exp_rsp);
         check("bp_ready", cmd_ready, 0);
         check("bp_no_wr", mem_wr_en, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      mem_rd_bus = BUS_IDLE;
      check("rsp_cleared", rsp_valid, 0);
      check("rsp_ready_back", cmd_ready, 1);
      check("rsp_busy_end", busy, 0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 2'd0, 16'h0010, 5'd0,  2'd0, 32'hDEAD_BEEF, 32'h0, 0, 32'h0};
      vecs[1] = '{1'b0, 2'd0, 16'h0010, 5'd0,  2'd0, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 2'd1, 16'h1234, 5'd31, 2'd0, 32'h0,         32'h0000_0001, 0, 32'h0000_0001};
      vecs[3] = '{1'b0, 2'd2, 16'hFFFF, 5'd0,  2'd3, 32'h0,         32'h0000_00AB, 0, 32'h0000_00AB};
      vecs[4] = '{1'b1, 2'd0, 16'hFFFF, 5'd0,  2'd0, 32'h0000_0000, 32'h0, 0, 32'h0};
      vecs[5] = '{1'b1, 2'd0, 16'h0001, 5'd0,  2'd0, 32'hFFFF_FFFF, 32'h0, 0, 32'h0};
      vecs[6] = '{1'b0, 2'd3, 16'h0000, 5'd7,  2'd1, 32'h5555_AAAA, 32'h0000_0008, 10, 32'h0000_0008};
      vecs[7] = '{1'b1, 2'd0, 16'h8000, 5'd0,  2'd0, 32'h0BAD_F00D, 32'h0, 0, 32'h0};

      // Reset held for three edges.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("in_reset_ready", cmd_ready, 0);
         check("in_reset_strobes", {mem_rd_en, mem_wr_en}, 0);
      end
      reset = 1'b1;
      tick();
      check("rst_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_sel", {mem_rd_opcode, mem_bit_addr, mem_byte_addr}, 0);
      check("rst_wr_bus", mem_wr_bus, 0);
`ifdef REQ_STATS_EN
      check("rst_counts", {rd_count, wr_count}, 0);
`endif

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].is_wr) do_write(vecs[i]);
         else               do_read(vecs[i]);
      end

`ifdef REQ_STATS_EN
      check("wr_count", wr_count, exp_wr);
      check("rd_count", rd_count, exp_rd);
      force dut.rd_count_q = 16'hFFFF;
      tick();
      release dut.rd_count_q;
      do_read(vecs[1]);
      check("rd_count_sat", rd_count, 16'hFFFF);
`endif

      // Reset asserted while a read sits in RD_HOLD.
      drive_cmd(vecs[2]);
      tick();
      cmd_valid = 1'b0;
      check("abort_rd_strobe", mem_rd_en, 1);
      tick();
      check("abort_in_hold", dbg_state, 3'd2);
      reset = 1'b0;
      #1;
      check("abort_ready_now", cmd_ready, 0);
      tick();
      check("abort_rsp", rsp_valid, 0);
      check("abort_strobes", {mem_rd_en, mem_wr_en}, 0);
      check("abort_busy", busy, 0);
      tick();
      check("abort_rsp_later", rsp_valid, 0);
      reset = 1'b1;
      tick();
      do_write(vecs[7]);

      // Reset during a write ISSUE drops the strobe combinationally.
      drive_cmd(vecs[0]);
      tick();
      cmd_valid = 1'b0;
      check("wabort_strobe", mem_wr_en, 1);
      reset = 1'b0;
      #1;
      check("wabort_strobe_gated", mem_wr_en, 0);
      tick();
      reset = 1'b1;
      tick();
      check("wabort_idle", busy, 0);
      do_write(vecs[5]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
